sm4_round_ctrl: RTL and testbench
=================================

// Module: sm4_round_ctrl
// PURPOSE
//  Iterative SM4 block-cipher engine controller: accepts one 128-bit block, sequences
//  32 applications of the single-round function over a 4x32-bit state register,
//  fetches one round key per round from an external key store, applies the final
//  word reversal, and holds the result until the consumer accepts it.
//  Sits between the host data interface and the round-key store.
// PARAMETERS
//  ROUNDS  32  rounds per block; 32 for SM4, smaller values for debug only
//  RK_AW   5   round-key address width; must satisfy 2**RK_AW >= ROUNDS
// PORTS
//  CLK_i        in   1      clock, all state on rising edge
//  RST_i        in   1      reset, asynchronous, active-high
//  DAT_i        in   128    plaintext/ciphertext block {X0,X1,X2,X3}, X0 = [127:96]
//  DAT_VALID_i  in   1      DAT_i valid
//  DAT_READY_o  out  1      block accepted on an edge where DAT_VALID_i & DAT_READY_o
//  DEC_i        in   1      1 = decrypt (reverse key order); sampled at accept
//  RK_ADDR_o    out  RK_AW  round-key index for the current round
//  RK_i         in   32     round key rk[RK_ADDR_o], combinational, same cycle
//  DAT_o        out  128    result {X35,X34,X33,X32}
//  DAT_VALID_o  out  1      DAT_o valid
//  DAT_READY_i  in   1      consumer accepts DAT_o
//  BUSY_o       out  1      rounds in progress
// BEHAVIOUR
//  - Single clock CLK_i; reset is asynchronous and active-high on RST_i.
//  - Reset values: state IDLE, round counter 0, state regs 0, DAT_o 0,
//    DAT_VALID_o 0, BUSY_o 0, RK_ADDR_o 0; DAT_READY_o 1 (IDLE) after release.
//  - FSM: IDLE -> RUN on accept; RUN -> DONE when the round with cnt == ROUNDS-1
//    completes; DONE -> IDLE on DAT_VALID_o & DAT_READY_i.
//  - DAT_READY_o = (state == IDLE). DAT_VALID_i in RUN/DONE is ignored, not queued.
//  - Accept edge: X0..X3 <= DAT_i words, cnt <= 0, dec_q <= DEC_i.
//  - RUN, each edge: X0..X3 <= {X1,X2,X3, X0 ^ L(tau(X1^X2^X3^RK_i))}; cnt++.
//  - RK_ADDR_o = dec_q ? ROUNDS-1-cnt : cnt in RUN; 0 otherwise.
//  - L(b) = b ^ rol(b,2) ^ rol(b,10) ^ rol(b,18) ^ rol(b,24); tau = four parallel S-boxes.
//  - Latency: DAT_VALID_o rises exactly ROUNDS cycles after the accept edge; BUSY_o
//    is high for exactly those ROUNDS cycles.
//  - DAT_o is registered on the final round edge as {X3,X2,X1,X0} (reversal) and is
//    stable for the whole DONE period regardless of DAT_READY_i; DAT_o retains its
//    value in IDLE.
//  - Throughput: one block per ROUNDS+2 cycles with DAT_READY_i held high.
//  - cnt is ceil(log2(ROUNDS+1)) bits wide and never wraps; cnt is not advanced in DONE.
//  - RST_i asserted mid-RUN or mid-DONE: block discarded, all regs return to reset
//    values immediately; no partial result is ever flagged valid.
// CONFIGURATION
//  - SM4_DEC_EN defined: DEC_i honoured as above.
//  - SM4_DEC_EN undefined: DEC_i ignored, dec_q tied to 0, engine is encrypt-only
//    and RK_ADDR_o counts 0..ROUNDS-1.
// STRUCTURE
//  - Package sm4_pkg: SM4_ROUNDS = 32, FSM state typedef {IDLE,RUN,DONE},
//    256-entry S-box constant table, function sm4_l(), function sm4_tau().
//  - One sub-module sm4_round_f: purely combinational
//    (X0..X3, rk) -> X0 ^ L(tau(X1^X2^X3^rk)); controller owns all registers.
// TESTING
//  - Encrypt, key 0123456789abcdeffedcba9876543210 (store loaded with its rk, rk0 = F12186F9,
//    rk31 = 9124A012), DAT_i = 0123456789abcdeffedcba9876543210
//    -> DAT_o = 681edf34d206965e86b3e94f536e4246, DAT_VALID_o 32 cycles after accept.
//  - SM4_DEC_EN, DEC_i=1, DAT_i = 681edf34d206965e86b3e94f536e4246
//    -> DAT_o = 0123456789abcdeffedcba9876543210; RK_ADDR_o sequence 31,30..0.
//  - Backpressure: DAT_READY_i low 5 cycles in DONE -> DAT_o/DAT_VALID_o stable,
//    DAT_READY_o low; release -> IDLE next cycle, DAT_READY_o = 1.
//  - DAT_VALID_i held high with new data throughout RUN -> ignored, result of first block
//    unchanged; second block accepted only after DONE handshake (ROUNDS+2 cycle spacing).
//  - RST_i pulsed at round 10 -> DAT_VALID_o never asserted for that block, BUSY_o = 0,
//    next block encrypts correctly.
//  - Without SM4_DEC_EN, DEC_i=1 -> encryption result, RK_ADDR_o ascends 0..31.

Source files
------------

// File: rtl/sm4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm4_pkg : shared SM4 constants, controller state type, S-box, tau and L |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sm4_pkg;

    localparam int SM4_ROUNDS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sm4_state_e;

    localparam logic [7:0] SM4_SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] sm4_tau(input logic [31:0] a);
        return {SM4_SBOX[a[31:24]], SM4_SBOX[a[23:16]], SM4_SBOX[a[15:8]], SM4_SBOX[a[7:0]]};
    endfunction

    // Linear diffusion: b ^ rol2 ^ rol10 ^ rol18 ^ rol24
    function automatic logic [31:0] sm4_l(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm4_round_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm4_round_ctrl_if : host data, result and round-key store signal bundle |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sm4_round_ctrl_if #(
    parameter int RK_AW = 5
);
    logic [127:0]     DAT_i;
    logic             DAT_VALID_i;
    logic             DAT_READY_o;
    logic             DEC_i;
    logic [RK_AW-1:0] RK_ADDR_o;
    logic [31:0]      RK_i;
    logic [127:0]     DAT_o;
    logic             DAT_VALID_o;
    logic             DAT_READY_i;
    logic             BUSY_o;

    modport slave (
        input  DAT_i, DAT_VALID_i, DEC_i, RK_i, DAT_READY_i,
        output DAT_READY_o, RK_ADDR_o, DAT_o, DAT_VALID_o, BUSY_o
    );

    modport master (
        output DAT_i, DAT_VALID_i, DEC_i, RK_i, DAT_READY_i,
        input  DAT_READY_o, RK_ADDR_o, DAT_o, DAT_VALID_o, BUSY_o
    );
endinterface
`default_nettype wire

// File: rtl/sm4_round_f.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm4_round_f : combinational SM4 round, X0 ^ L(tau(X1 ^ X2 ^ X3 ^ rk))    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sm4_round_f
    import sm4_pkg::*;
(
    input  wire logic [31:0] i_x0,
    input  wire logic [31:0] i_x1,
    input  wire logic [31:0] i_x2,
    input  wire logic [31:0] i_x3,
    input  wire logic [31:0] i_rk,
    output logic      [31:0] o_x
);
    logic [31:0] w_mix;

    assign w_mix = i_x1 ^ i_x2 ^ i_x3 ^ i_rk;
    assign o_x   = i_x0 ^ sm4_l(sm4_tau(w_mix));
endmodule
`default_nettype wire

// File: rtl/sm4_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm4_round_ctrl : iterative SM4 engine controller; SM4_DEC_EN enables DEC |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sm4_round_ctrl
    import sm4_pkg::*;
#(
    parameter int ROUNDS = SM4_ROUNDS,
    parameter int RK_AW  = 5
)(
    input wire logic        CLK_i,
    input wire logic        RST_i,
    sm4_round_ctrl_if.slave bus
);
    localparam int              CNT_W  = $clog2(ROUNDS + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ROUNDS - 1);

    sm4_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      x0_q, x0_d;
    logic [31:0]      x1_q, x1_d;
    logic [31:0]      x2_q, x2_d;
    logic [31:0]      x3_q, x3_d;
    logic             dec_q, dec_d;
    logic [127:0]     dat_o_q, dat_o_d;

    logic [31:0]      round_out;
    logic [CNT_W-1:0] rk_idx;
    logic [RK_AW-1:0] rk_addr;

    sm4_round_f u_round (
        .i_x0 (x0_q),
        .i_x1 (x1_q),
        .i_x2 (x2_q),
        .i_x3 (x3_q),
        .i_rk (bus.RK_i),
        .o_x  (round_out)
    );

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            dec_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            x3_q    <= x3_d;
            dec_q   <= dec_d;
            dat_o_q <= dat_o_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        x3_d    = x3_q;
        dec_d   = dec_q;
        dat_o_d = dat_o_q;

        unique case (state_q)
            IDLE: begin
                if (bus.DAT_VALID_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    {x0_d, x1_d, x2_d, x3_d} = bus.DAT_i;
`ifdef SM4_DEC_EN
                    dec_d   = bus.DEC_i;
`else
                    dec_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                x0_d  = x1_q;
                x1_d  = x2_q;
                x2_d  = x3_q;
                x3_d  = round_out;
                cnt_d = cnt_q + CNT_W'(1);
                // Last round: capture {X35,X34,X33,X32} directly, already reversed
                if (cnt_q == C_LAST) begin
                    state_d = DONE;
                    dat_o_d = {round_out, x3_q, x2_q, x1_q};
                end
            end
            DONE: begin
                if (bus.DAT_READY_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rk_idx  = dec_q ? (C_LAST - cnt_q) : cnt_q;
        rk_addr = '0;
        if (state_q == RUN) begin
            rk_addr = RK_AW'(rk_idx);
        end
    end

    assign bus.RK_ADDR_o   = rk_addr;
    assign bus.DAT_READY_o = (state_q == IDLE);
    assign bus.DAT_VALID_o = (state_q == DONE);
    assign bus.BUSY_o      = (state_q == RUN);
    assign bus.DAT_o       = dat_o_q;

endmodule
`default_nettype wire

// File: tb/tb_sm4_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sm4_round_ctrl : randomized bench with a block-level SM4 model        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sm4_round_ctrl;

    localparam int ROUNDS = 32;
`ifdef SM4_DEC_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    localparam logic [2047:0] SBOX_PK = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] rk_mem [32];

    sm4_round_ctrl_if #(.RK_AW(5)) bus ();

    sm4_round_ctrl #(.ROUNDS(ROUNDS), .RK_AW(5)) dut (
        .CLK_i (clk),
        .RST_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.RK_i = rk_mem[bus.RK_ADDR_o];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- block-level reference model ----------------
    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[31-8*b -: 8] = SBOX_PK[2047 - 8*int'(a[31-8*b -: 8]) -: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] lin(input logic [31:0] t);
        return t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
    endfunction

    task automatic expand_key(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck;
        logic [31:0] t;
        k[0] = mk[127:96] ^ 32'hA3B1BAC6;
        k[1] = mk[95:64]  ^ 32'h56AA3350;
        k[2] = mk[63:32]  ^ 32'h677D9197;
        k[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'((4*i + j) * 7);
            t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
            rk_mem[i] = k[i+4];
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] blk, input bit dec);
        logic [31:0] x [36];
        x[0] = blk[127:96]; x[1] = blk[95:64]; x[2] = blk[63:32]; x[3] = blk[31:0];
        for (int i = 0; i < 32; i++) begin
            x[i+4] = x[i] ^ lin(tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk_mem[dec ? 31 - i : i]));
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [127:0] din, input logic dec);
        int guard = 0;
        bus.DAT_i       = din;
        bus.DEC_i       = dec;
        bus.DAT_VALID_i = 1'b1;
        while (!bus.DAT_READY_o && guard < 200) begin
            tick();
            guard++;
        end
        chk("accept_ready", 128'(bus.DAT_READY_o), 128'(1));
        tick();
        acc_cyc = cyc;
        bus.DAT_VALID_i = 1'b0;
    endtask

    task automatic finish_block(input logic [127:0] exp, input bit dec_eff, input int stall);
        int         lat = 0;
        logic [4:0] ea;
        bus.DAT_READY_i = (stall == 0);
        while (!bus.DAT_VALID_o && lat < 100) begin
            ea = dec_eff ? 5'(ROUNDS - 1 - lat) : 5'(lat);
            chk("busy_run", 128'(bus.BUSY_o), 128'(1));
            chk("rk_addr", 128'(bus.RK_ADDR_o), 128'(ea));
            chk("ready_run", 128'(bus.DAT_READY_o), 128'(0));
            tick();
            lat++;
        end
        chk("latency", 128'(lat), 128'(ROUNDS));
        chk("result", bus.DAT_o, exp);
        chk("busy_done", 128'(bus.BUSY_o), 128'(0));
        for (int s = 0; s < stall; s++) begin
            tick();
            chk("bp_valid", 128'(bus.DAT_VALID_o), 128'(1));
            chk("bp_data", bus.DAT_o, exp);
            chk("bp_ready", 128'(bus.DAT_READY_o), 128'(0));
            chk("bp_addr", 128'(bus.RK_ADDR_o), 128'(0));
        end
        bus.DAT_READY_i = 1'b1;
        tick();
        chk("idle_ready", 128'(bus.DAT_READY_o), 128'(1));
        chk("idle_valid", 128'(bus.DAT_VALID_o), 128'(0));
        chk("idle_hold", bus.DAT_o, exp);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] b1, b2, mk;
        int unsigned  a1;
        bit           d, saw;

        bus.DAT_i = '0; bus.DAT_VALID_i = 1'b0; bus.DEC_i = 1'b0; bus.DAT_READY_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("rst_ready", 128'(bus.DAT_READY_o), 128'(1));
        chk("rst_valid", 128'(bus.DAT_VALID_o), 128'(0));
        chk("rst_busy", 128'(bus.BUSY_o), 128'(0));
        chk("rst_addr", 128'(bus.RK_ADDR_o), 128'(0));
        chk("rst_dat", bus.DAT_o, 128'(0));

        // Known-answer encrypt
        expand_key(128'h0123456789abcdeffedcba9876543210);
        start_block(128'h0123456789abcdeffedcba9876543210, 1'b0);
        finish_block(128'h681edf34d206965e86b3e94f536e4246, 1'b0, 0);

        // Decrypt known answer, or DEC_i ignored in an encrypt-only build
        if (DEC_EN) begin
            start_block(128'h681edf34d206965e86b3e94f536e4246, 1'b1);
            finish_block(128'h0123456789abcdeffedcba9876543210, 1'b1, 0);
        end else begin
            start_block(128'h0123456789abcdeffedcba9876543210, 1'b1);
            finish_block(128'h681edf34d206965e86b3e94f536e4246, 1'b0, 0);
        end

        // Backpressure in DONE
        b1 = {$urandom, $urandom, $urandom, $urandom};
        start_block(b1, 1'b0);
        finish_block(model(b1, 1'b0), 1'b0, 5);

        // Valid held high with new data through RUN
        b1 = {$urandom, $urandom, $urandom, $urandom};
        b2 = {$urandom, $urandom, $urandom, $urandom};
        start_block(b1, 1'b0);
        a1 = acc_cyc;
        bus.DAT_i = b2;
        bus.DAT_VALID_i = 1'b1;
        finish_block(model(b1, 1'b0), 1'b0, 0);
        start_block(b2, 1'b0);
        chk("spacing", 128'(acc_cyc - a1), 128'(ROUNDS + 2));
        finish_block(model(b2, 1'b0), 1'b0, 0);

        // Reset in the middle of round processing
        b1 = {$urandom, $urandom, $urandom, $urandom};
        start_block(b1, 1'b0);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(bus.BUSY_o), 128'(0));
        chk("midrst_valid", 128'(bus.DAT_VALID_o), 128'(0));
        chk("midrst_dat", bus.DAT_o, 128'(0));
        chk("midrst_addr", 128'(bus.RK_ADDR_o), 128'(0));
        tick();
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            tick();
            if (bus.DAT_VALID_o || bus.BUSY_o) saw = 1'b1;
        end
        chk("midrst_quiet", 128'(saw), 128'(0));
        b2 = {$urandom, $urandom, $urandom, $urandom};
        start_block(b2, 1'b0);
        finish_block(model(b2, 1'b0), 1'b0, 0);

        // Random keys, blocks, directions and backpressure
        for (int n = 0; n < 16; n++) begin
            mk = {$urandom, $urandom, $urandom, $urandom};
            expand_key(mk);
            b1 = {$urandom, $urandom, $urandom, $urandom};
            d  = 1'($urandom_range(0, 1));
            start_block(b1, d);
            finish_block(model(b1, d & DEC_EN), d & DEC_EN, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
